// File: rtl/instr_register_calc.sv
// instr_register_calc: addressable instruction register file that computes
// each entry's result on write. DIV/MOD use an iterative restoring divider
// (one quotient bit per clock), during which writes are stalled.
// Optional build macro: INSTR_REG_ERR_FLAG_EN adds a per-entry error bit
// (set for divide-by-zero and opcodes 8..15); without it rd_err is 0.
module instr_register_calc #(
  parameter int OP_W   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [3:0]          wr_opcode,
  input  logic [OP_W-1:0]     wr_op_a,
  input  logic [OP_W-1:0]     wr_op_b,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_data_valid,
  output logic [3:0]          rd_opcode,
  output logic [OP_W-1:0]     rd_op_a,
  output logic [OP_W-1:0]     rd_op_b,
  output logic [2*OP_W-1:0]   rd_res,
  output logic                rd_err,
  output logic                busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int RES_W = 2 * OP_W;
  localparam int CNT_W = $clog2(OP_W + 1);

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {IDLE, DIV, WB} state_t;

  state_t state, state_next;

  // Storage
  logic [3:0]       mem_opcode [DEPTH];
  logic [OP_W-1:0]  mem_op_a   [DEPTH];
  logic [OP_W-1:0]  mem_op_b   [DEPTH];
  logic [RES_W-1:0] mem_res    [DEPTH];
`ifdef INSTR_REG_ERR_FLAG_EN
  logic             mem_err    [DEPTH];
  logic             w_err;
`endif

  // Write-side decode
  logic accept, is_divmod, start_div, direct_wr;
  logic [RES_W-1:0] a_ext, b_ext, direct_res;
  logic [OP_W-1:0]  a_mag, b_mag;

  // Divider state
  logic [ADDR_W-1:0] div_addr;
  logic [3:0]        div_op;
  logic [OP_W-1:0]   div_a, div_b, div_d, div_q, div_rem;
  logic              div_neg_q, div_neg_r;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W:0]     shifted, diff;
  logic              ge;
  logic [RES_W-1:0]  q_ext, r_ext, wb_res;

  // Memory write port
  logic              mem_we;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_opcode;
  logic [OP_W-1:0]   w_op_a, w_op_b;
  logic [RES_W-1:0]  w_res;

  assign wr_ready  = (state == IDLE);
  assign busy      = ~wr_ready;
  assign accept    = wr_valid && wr_ready;
  assign is_divmod = (wr_opcode == OP_DIV) || (wr_opcode == OP_MOD);
  assign start_div = accept && is_divmod && (wr_op_b != '0);
  assign direct_wr = accept && !start_div;

  assign a_ext = {{OP_W{wr_op_a[OP_W-1]}}, wr_op_a};
  assign b_ext = {{OP_W{wr_op_b[OP_W-1]}}, wr_op_b};
  assign a_mag = wr_op_a[OP_W-1] ? (~wr_op_a + OP_W'(1)) : wr_op_a;
  assign b_mag = wr_op_b[OP_W-1] ? (~wr_op_b + OP_W'(1)) : wr_op_b;

  // Single-cycle results; DIV/MOD only reach here with a zero divisor
  always_comb begin
    direct_res = '0;
    case (wr_opcode)
      OP_PASSA: direct_res = a_ext;
      OP_PASSB: direct_res = b_ext;
      OP_ADD:   direct_res = a_ext + b_ext;
      OP_SUB:   direct_res = a_ext - b_ext;
      OP_MULT:  direct_res = a_ext * b_ext;
      default:  direct_res = '0;
    endcase
  end

  // One restoring-division step: the dividend shifts out of div_q MSB-first
  // while quotient bits shift in at the bottom.
  assign shifted = {div_rem, div_q[OP_W-1]};
  assign diff    = shifted - {1'b0, div_d};
  assign ge      = ~diff[OP_W];
  assign q_ext   = {{OP_W{1'b0}}, div_q};
  assign r_ext   = {{OP_W{1'b0}}, div_rem};
  assign wb_res  = (div_op == OP_MOD)
                 ? (div_neg_r ? (~r_ext + RES_W'(1)) : r_ext)
                 : (div_neg_q ? (~q_ext + RES_W'(1)) : q_ext);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_div) state_next = DIV;
      DIV:     if (cnt == CNT_W'(1)) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider operand latch and iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_addr  <= '0;
      div_op    <= '0;
      div_a     <= '0;
      div_b     <= '0;
      div_d     <= '0;
      div_q     <= '0;
      div_rem   <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      cnt       <= '0;
    end else if (start_div) begin
      div_addr  <= wr_addr;
      div_op    <= wr_opcode;
      div_a     <= wr_op_a;
      div_b     <= wr_op_b;
      div_d     <= b_mag;
      div_q     <= a_mag;
      div_rem   <= '0;
      div_neg_q <= wr_op_a[OP_W-1] ^ wr_op_b[OP_W-1];
      div_neg_r <= wr_op_a[OP_W-1];
      cnt       <= CNT_W'(OP_W);
    end else if (state == DIV) begin
      div_q   <= {div_q[OP_W-2:0], ge};
      div_rem <= ge ? diff[OP_W-1:0] : shifted[OP_W-1:0];
      cnt     <= cnt - CNT_W'(1);
    end
  end

  // Write-port mux: divider writeback or an immediate write from IDLE
  always_comb begin
    mem_we   = 1'b0;
    w_addr   = wr_addr;
    w_opcode = wr_opcode;
    w_op_a   = wr_op_a;
    w_op_b   = wr_op_b;
    w_res    = direct_res;
`ifdef INSTR_REG_ERR_FLAG_EN
    w_err    = wr_opcode[3] || is_divmod;
`endif
    if (state == WB) begin
      mem_we   = 1'b1;
      w_addr   = div_addr;
      w_opcode = div_op;
      w_op_a   = div_a;
      w_op_b   = div_b;
      w_res    = wb_res;
`ifdef INSTR_REG_ERR_FLAG_EN
      w_err    = 1'b0;
`endif
    end else if (direct_wr) begin
      mem_we = 1'b1;
    end
  end

  // Register file storage, cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_opcode[i] <= '0;
        mem_op_a[i]   <= '0;
        mem_op_b[i]   <= '0;
        mem_res[i]    <= '0;
`ifdef INSTR_REG_ERR_FLAG_EN
        mem_err[i]    <= 1'b0;
`endif
      end
    end else if (mem_we) begin
      mem_opcode[w_addr] <= w_opcode;
      mem_op_a[w_addr]   <= w_op_a;
      mem_op_b[w_addr]   <= w_op_b;
      mem_res[w_addr]    <= w_res;
`ifdef INSTR_REG_ERR_FLAG_EN
      mem_err[w_addr]    <= w_err;
`endif
    end
  end

  // Registered read port; samples pre-write contents, outputs hold between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_valid <= 1'b0;
      rd_opcode     <= '0;
      rd_op_a       <= '0;
      rd_op_b       <= '0;
      rd_res        <= '0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) begin
        rd_opcode <= mem_opcode[rd_addr];
        rd_op_a   <= mem_op_a[rd_addr];
        rd_op_b   <= mem_op_b[rd_addr];
        rd_res    <= mem_res[rd_addr];
      end
    end
  end

`ifdef INSTR_REG_ERR_FLAG_EN
  // Error flag read alongside the rest of the entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_err <= 1'b0;
    else if (rd_en) rd_err <= mem_err[rd_addr];
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_register_calc.sv
// Scoreboard testbench for instr_register_calc (OP_W=32, ADDR_W=5).
module tb_instr_register_calc;

  localparam int OP_W   = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_opcode;
  logic [31:0] wr_op_a, wr_op_b;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        rd_data_valid;
  logic [3:0]  rd_opcode;
  logic [31:0] rd_op_a, rd_op_b;
  logic [63:0] rd_res;
  logic        rd_err;
  logic        busy;

  instr_register_calc #(.OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_opcode(wr_opcode), .wr_op_a(wr_op_a), .wr_op_b(wr_op_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_valid(rd_data_valid),
    .rd_opcode(rd_opcode), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
    .rd_res(rd_res), .rd_err(rd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        err;
  } entry_t;

  entry_t model [DEPTH];
  entry_t exp_q [$];
  entry_t pend_e;
  int     pend_addr;
  bit     pend;
  int     checks = 0;
  int     errors = 0;
  int     run    = 0;

  function automatic entry_t make_entry(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    entry_t e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1:    r = sa;
      4'd2:    r = sb;
      4'd3:    r = sa + sb;
      4'd4:    r = sa - sb;
      4'd5:    r = sa * sb;
      4'd6:    r = (sb == 0) ? 0 : sa / sb;
      4'd7:    r = (sb == 0) ? 0 : sa % sb;
      default: r = 0;
    endcase
    e.op = op; e.a = a; e.b = b; e.res = 64'(r);
`ifdef INSTR_REG_ERR_FLAG_EN
    e.err = (op >= 4'd8) || ((op == 4'd6 || op == 4'd7) && sb == 0);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  function automatic entry_t zero_entry();
    entry_t e;
    e.op = '0; e.a = '0; e.b = '0; e.res = '0; e.err = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // Wait for the block to be idle, committing any divide that has completed
  task automatic wait_idle();
    int n = 0;
    while (!wr_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wr_ready) begin
      errors++;
      $display("FAIL wait_idle: wr_ready=%0b required 1 within 200 cycles", wr_ready);
    end
    if (pend) begin
      model[pend_addr] = pend_e;
      pend = 1'b0;
    end
  endtask

  task automatic do_write(int addr, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                          bit with_read = 1'b0);
    entry_t e;
    bit stall;
    wr_addr = 5'(addr); wr_opcode = op; wr_op_a = a; wr_op_b = b;
    wr_valid = 1'b1;
    wait_idle();
    if (with_read) begin
      rd_en = 1'b1; rd_addr = 5'(addr);
      exp_q.push_back(model[addr]);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_en = 1'b0;
    e = make_entry(op, a, b);
    stall = (op == 4'd6 || op == 4'd7) && (b != 0);
    checks++;
    if (wr_ready !== !stall) begin
      errors++;
      $display("FAIL wr_ready_after_accept op=%0d: got %0b required %0b", op, wr_ready, !stall);
    end
    if (stall) begin
      pend = 1'b1; pend_addr = addr; pend_e = e;
    end else begin
      model[addr] = e;
    end
  endtask

  task automatic do_read(int addr);
    wait_idle();
    rd_en = 1'b1; rd_addr = 5'(addr);
    exp_q.push_back(model[addr]);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic check_val(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: compare every read response against the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rd_data_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: rd_data_valid=1 required 0");
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if (rd_opcode !== e.op || rd_op_a !== e.a || rd_op_b !== e.b ||
            rd_res !== e.res || rd_err !== e.err) begin
          errors++;
          $display("FAIL read_data: got op=%0d a=%h b=%h res=%h err=%0b required op=%0d a=%h b=%h res=%h err=%0b",
                   rd_opcode, rd_op_a, rd_op_b, rd_res, rd_err, e.op, e.a, e.b, e.res, e.err);
        end
      end
    end
  end

  // Stall-length and busy/wr_ready consistency monitor
  always @(negedge clk) begin
    checks++;
    if (busy !== !wr_ready) begin
      errors++;
      $display("FAIL busy_vs_ready: busy=%0b required %0b", busy, !wr_ready);
    end
    if (reset_n !== 1'b1) run = 0;
    else if (!wr_ready) run++;
    else if (run != 0) begin
      checks++;
      if (run != OP_W + 1) begin
        errors++;
        $display("FAIL stall_length: got %0d cycles required %0d", run, OP_W + 1);
      end
      run = 0;
    end
  end

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_opcode = '0;
    wr_op_a = '0; wr_op_b = '0; rd_en = 1'b0; rd_addr = '0; pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = zero_entry();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_wr_ready", 64'(wr_ready), 64'd1);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_rd_valid", 64'(rd_data_valid), 64'd0);
    check_val("reset_rd_res", rd_res, 64'd0);
    check_val("reset_rd_opcode", 64'(rd_opcode), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) do_read(i);

    // Back-to-back single-cycle ops
    do_write(3, 4'd3, 32'd5, -32'sd7);
    do_write(4, 4'd5, 32'h7FFF_FFFF, 32'd2);
    do_read(3);
    do_read(4);
    repeat (3) @(posedge clk);
    #1;
    check_val("rd_hold_res", rd_res, 64'h0000_0000_FFFF_FFFE);

    // Divider: DIV then MOD presented while stalled, and overflow case
    do_write(5, 4'd6, -32'sd7, 32'd2);
    do_write(6, 4'd7, -32'sd7, 32'd2);
    do_write(11, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_read(5);
    do_read(6);
    do_read(11);

    // Divide by zero and undefined opcode: no stall, result 0
    do_write(7, 4'd6, 32'd9, 32'd0);
    do_write(8, 4'hA, 32'd3, 32'd4);
    do_read(7);
    do_read(8);

    // Reset while dividing discards the pending op and clears the memory
    do_write(9, 4'd1, 32'd1, 32'd0);
    do_write(9, 4'd6, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("abort_wr_ready", 64'(wr_ready), 64'd1);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_rd_res", rd_res, 64'd0);
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = zero_entry();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_read(9);
    do_read(3);

    // Same-edge read and write return the old contents
    do_write(10, 4'd4, 32'd5, 32'd2);
    do_write(10, 4'd2, 32'd0, 32'd42, 1'b1);
    do_read(10);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      do_write(int'($urandom_range(0, DEPTH - 1)), op, pick_operand(), pick_operand());
      if ($urandom_range(0, 2) == 0) do_read(int'($urandom_range(0, DEPTH - 1)));
    end
    for (int i = 0; i < DEPTH; i++) do_read(i);

    repeat (4) @(posedge clk);
    #1;
    check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
